// File: rtl/pipo_write_arbiter.sv
// -----------------------------------------------------------------------------
// pipo_write_arbiter
//
// Round-robin arbiter and write sequencer for a shared parallel-in/parallel-out
// register. NREQ requesters each present a request and a data word. The block
// grants one requester at a time and loads that requester's word into the
// internal register. It also reports the register contents, the last writer
// and a "written at least once" flag.
//
// Parameters
//   NREQ      number of requesters (>= 2)
//   WIDTH     register / data word width in bits
//   LOCK_MAX  max consecutive locked writes (used only with the lock option)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-low
//   req      in   [NREQ]        request, bit i = requester i
//   lock     in   [NREQ]        hold-grant request (only with PIPO_ARB_LOCK_EN)
//   wdata    in   [NREQ*WIDTH]  requester i's word at [i*WIDTH +: WIDTH]
//   gnt      out  [NREQ]        one-hot grant, all-zero when idle
//   q        out  [WIDTH]       register contents
//   q_valid  out                register written at least once since reset
//   owner    out  [clog2(NREQ)] index of the last successful writer
//   busy     out                high while the FSM is in GRANT
//
// Configuration macro
//   PIPO_ARB_LOCK_EN  adds the lock port. A locked winner keeps the grant and
//                     writes fresh data every cycle, up to LOCK_MAX writes.
//                     When the macro is undefined, every grant is a
//                     single-cycle write.
//
// Timing
//   A request seen at edge k is granted during cycle k..k+1, and the register
//   is written at edge k+1. The IDLE cycle between grants is the arbitration
//   slot, so at most one unlocked write happens every two cycles.
// -----------------------------------------------------------------------------
module pipo_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 4,
    parameter int LOCK_MAX = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
`ifdef PIPO_ARB_LOCK_EN
    input  logic [NREQ-1:0]               lock,
`endif
    input  logic [NREQ*WIDTH-1:0]         wdata,
    output logic [NREQ-1:0]               gnt,
    output logic [WIDTH-1:0]              q,
    output logic                          q_valid,
    output logic [$clog2(NREQ)-1:0]       owner,
    output logic                          busy
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || LOCK_MAX < 1) begin : g_bad_params
        $error("pipo_write_arbiter: NREQ must be >= 2 and LOCK_MAX >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   ptr;       // highest-priority requester for the next arbitration
    logic [IW-1:0]   winner;    // requester holding the current grant
    logic [IW-1:0]   pick;      // combinational arbitration result
    logic            found;     // at least one request present
    logic            write_ok;  // the winner still requests at the closing edge
    logic            lock_go;   // stay in GRANT for another locked write
    logic            prior_writes; // earlier writes happened during this grant
    logic [IW-1:0]   winner_inc;

`ifdef PIPO_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0]   lock_cnt;  // writes completed so far in this locked grant
`endif

    // Round-robin search: the first set request bit starting at ptr, moving
    // upward and wrapping from NREQ-1 to 0.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end

    assign write_ok   = req[winner];
    assign winner_inc = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;

`ifdef PIPO_ARB_LOCK_EN
    always_comb begin
        lock_go      = lock[winner] && write_ok && (lock_cnt != CW'(LOCK_MAX - 1));
        prior_writes = (lock_cnt != '0);
    end
`else
    always_comb begin
        lock_go      = 1'b0;
        prior_writes = 1'b0;
    end
`endif

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = found ? GRANT : IDLE;
            GRANT:   state_next = lock_go ? GRANT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // gnt and busy are decoded from registered state only, so there is no
    // combinational path from req to gnt.
    always_comb begin
        gnt  = '0;
        busy = 1'b0;
        if (state == GRANT) begin
            gnt[winner] = 1'b1;
            busy        = 1'b1;
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            winner   <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
            owner    <= '0;
`ifdef PIPO_ARB_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        winner <= pick;
                    end
`ifdef PIPO_ARB_LOCK_EN
                    lock_cnt <= '0;
`endif
                end
                GRANT: begin
                    // A withdrawn request skips the write. ptr moves on only
                    // when this grant produced at least one write.
                    if (write_ok) begin
                        q       <= wdata[int'(winner)*WIDTH +: WIDTH];
                        owner   <= winner;
                        q_valid <= 1'b1;
                    end
                    if (!lock_go && (write_ok || prior_writes)) begin
                        ptr <= winner_inc;
                    end
`ifdef PIPO_ARB_LOCK_EN
                    if (lock_go) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipo_write_arbiter
//
// Directed bench for pipo_write_arbiter (NREQ=4, WIDTH=4, LOCK_MAX=3).
// Stimulus pushes one expected record per grant cycle into a queue. A monitor
// samples on the falling edge. When gnt is non-zero, it pops a record and
// checks gnt and busy. On the next falling edge it checks the q, owner and
// q_valid values that the closing edge produced. Reset behaviour is checked
// directly by the stimulus process. The lock test is compiled only when
// PIPO_ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipo_write_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 4;
    localparam int LOCK_MAX = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NREQ-1:0]         req = '0;
`ifdef PIPO_ARB_LOCK_EN
    logic [NREQ-1:0]         lock = '0;
`endif
    logic [NREQ*WIDTH-1:0]   wdata = '0;
    logic [NREQ-1:0]         gnt;
    logic [WIDTH-1:0]        q;
    logic                    q_valid;
    logic [1:0]              owner;
    logic                    busy;

    pipo_write_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
`ifdef PIPO_ARB_LOCK_EN
        .lock    (lock),
`endif
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] q;
        logic [1:0] owner;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_grant(input logic [3:0] g, input logic [3:0] qv, input logic [1:0] ow);
        exp_t e;
        e.gnt   = g;
        e.q     = qv;
        e.owner = ow;
        e.valid = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic set_word(input int i, input logic [3:0] v);
        wdata[i*WIDTH +: WIDTH] = v;
    endtask

    // ------------------------------------------------------------- monitor
    initial begin : monitor
        exp_t cur;
        exp_t pend;
        bit   pend_valid;
        pend_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend_valid = 1'b0;
            end else begin
                if (pend_valid) begin
                    check("q_after_grant",       q,       pend.q);
                    check("owner_after_grant",   owner,   pend.owner);
                    check("q_valid_after_grant", q_valid, pend.valid);
                    pend_valid = 1'b0;
                end
                if (gnt != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_gnt", gnt, 32'h0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("gnt", gnt, cur.gnt);
                        check("busy_during_gnt", busy, 1'b1);
                        pend       = cur;
                        pend_valid = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    initial begin : stimulus
        int budget;

        // Reset state.
        rst = 1'b0;
        step(2);
        check("rst_gnt",     gnt,     4'h0);
        check("rst_busy",    busy,    1'b0);
        check("rst_q",       q,       4'h0);
        check("rst_q_valid", q_valid, 1'b0);
        check("rst_owner",   owner,   2'd0);
        rst = 1'b1;
        step(1);

        // Test 1: traffic, then reset in the middle of a grant.
        set_word(0, 4'h9);
        req = 4'b0001;
        expect_grant(4'b0001, 4'h9, 2'd0);
        step(3);              // grant, write, second grant
        #1 rst = 1'b0;        // abort the second grant before its closing edge
        #1;
        check("abort_gnt",     gnt,     4'h0);
        check("abort_busy",    busy,    1'b0);
        check("abort_q",       q,       4'h0);
        check("abort_q_valid", q_valid, 1'b0);
        check("abort_owner",   owner,   2'd0);
        req = '0;
        step(1);
        rst = 1'b1;
        step(2);
        check("post_rst_q",       q,       4'h0);
        check("post_rst_q_valid", q_valid, 1'b0);

        // Test 2: single request from requester 2.
        set_word(2, 4'hA);
        req = 4'b0100;
        expect_grant(4'b0100, 4'hA, 2'd2);
        step(2);
        req = '0;
        step(1);
        check("single_gnt_idle", gnt,   4'h0);
        check("single_q",        q,     4'hA);
        check("single_owner",    owner, 2'd2);

        // Re-reset to bring the round-robin pointer back to 0.
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);

        // Test 3: fairness with all four requests held.
        set_word(0, 4'h1);
        set_word(1, 4'h2);
        set_word(2, 4'h3);
        set_word(3, 4'h4);
        req = 4'b1111;
        expect_grant(4'b0001, 4'h1, 2'd0);
        expect_grant(4'b0010, 4'h2, 2'd1);
        expect_grant(4'b0100, 4'h3, 2'd2);
        expect_grant(4'b1000, 4'h4, 2'd3);
        expect_grant(4'b0001, 4'h1, 2'd0);
        step(10);
        req = '0;
        step(1);
        check("fair_gnt_idle", gnt, 4'h0);

        // Test 4: wrap. A write by requester 2 leaves ptr=3. Then 3 wins before 0.
        set_word(0, 4'h3);
        set_word(2, 4'hC);
        set_word(3, 4'h8);
        req = 4'b0100;
        expect_grant(4'b0100, 4'hC, 2'd2);
        step(2);
        req = 4'b1001;
        expect_grant(4'b1000, 4'h8, 2'd3);
        expect_grant(4'b0001, 4'h3, 2'd0);
        step(4);
        req = '0;
        step(1);

        // Test 5: withdrawal during a grant. No write happens and ptr stays at 1.
        set_word(1, 4'h6);
        req = 4'b0010;
        expect_grant(4'b0010, 4'h3, 2'd0);   // q and owner unchanged from test 4
        step(1);
        req = '0;
        step(1);
        req = 4'b0011;
        expect_grant(4'b0010, 4'h6, 2'd1);
        expect_grant(4'b0001, 4'h3, 2'd0);
        step(4);
        req = '0;
        step(1);

`ifdef PIPO_ARB_LOCK_EN
        // Test 6: a locked requester 3 keeps the grant for LOCK_MAX writes, then
        // the pending requester 0 wins.
        req  = 4'b1001;
        lock = 4'b1000;
        set_word(3, 4'h5);
        expect_grant(4'b1000, 4'h5, 2'd3);
        expect_grant(4'b1000, 4'h6, 2'd3);
        expect_grant(4'b1000, 4'h7, 2'd3);
        expect_grant(4'b0001, 4'h3, 2'd0);
        step(2);              // grant, first write
        set_word(3, 4'h6);
        step(1);
        set_word(3, 4'h7);
        step(1);              // third write, back to IDLE
        set_word(3, 4'h8);
        req  = 4'b0001;
        lock = '0;
        check("lock_release_gnt", gnt, 4'h0);
        step(2);
        req = '0;
        step(1);
`endif

        // Drain the scoreboard. Every queued grant must have been seen.
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            step(1);
            budget++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
